// File: rtl/rca_pkg.sv
// Shared types for the pipelined ripple-carry adder.
package rca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_slice.sv
// W-bit combinational ripple-carry slice; also exposes the carry into its top bit
// so the MSB slice can form the signed-overflow term.
module rca_slice #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .sum (sum[i]),
            .cout(c[i+1])
        );
    end

    assign cout     = c[W];
    assign c_msb_in = c[W-1];

endmodule

// File: rtl/rca_pipe_nbit.sv
// Pipelined ripple-carry adder/subtractor: slice k of the operands is added in stage k,
// with registered inter-slice carries and skew registers for operands and partial sums.
module rca_pipe_nbit
    import rca_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  op_e              op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned W = WIDTH / STAGES;

    if (STAGES < 1 || WIDTH < 2 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("rca_pipe_nbit: need WIDTH >= 2, STAGES >= 1 and WIDTH divisible by STAGES");
    end

    logic                          adv;
    logic [WIDTH-1:0]              b_eff;
    logic                          cin_eff;
    logic                          ovf_d, ovf_q;
    logic [STAGES-1:0]             v_d, v_q, c_d, c_q, cm_w;
    logic [STAGES-1:0][WIDTH-1:0]  a_d, a_q, b_d, b_q, s_d, s_q;

    // One global enable: the whole pipe moves whenever the output slot can be refilled.
    assign adv      = !v_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; cin is ignored in that mode.
    assign b_eff   = (op == OP_SUB) ? ~b : b;
    assign cin_eff = (op == OP_SUB) ? 1'b1 : cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src, b_src, s_src, s_next;
        logic             v_src, c_src;
        logic [W-1:0]     s_slice;
        logic             co, cm;

        if (k == 0) begin : g_head
            assign a_src = a;
            assign b_src = b_eff;
            assign s_src = '0;
            assign v_src = in_valid;
            assign c_src = cin_eff;
        end else begin : g_body
            assign a_src = a_q[k-1];
            assign b_src = b_q[k-1];
            assign s_src = s_q[k-1];
            assign v_src = v_q[k-1];
            assign c_src = c_q[k-1];
        end

        rca_slice #(
            .W(W)
        ) u_slice (
            .a       (a_src[k*W +: W]),
            .b       (b_src[k*W +: W]),
            .cin     (c_src),
            .sum     (s_slice),
            .cout    (co),
            .c_msb_in(cm)
        );

        always_comb begin
            s_next            = s_src;
            s_next[k*W +: W]  = s_slice;
        end

        assign a_d[k]  = a_src;
        assign b_d[k]  = b_src;
        assign s_d[k]  = s_next;
        assign v_d[k]  = v_src;
        assign c_d[k]  = co;
        assign cm_w[k] = cm;
    end

    // Signed overflow: carry into the MSB differs from carry out of it.
    assign ovf_d = cm_w[STAGES-1] ^ c_d[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            c_q   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            ovf_q <= 1'b0;
        end else if (adv) begin
            v_q   <= v_d;
            c_q   <= c_d;
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign cout      = c_q[STAGES-1];
    assign ovf       = ovf_q;

    // Last-stage operand copies and non-MSB carry taps have no consumer.
    logic unused_skew;
    assign unused_skew = ^{a_q[STAGES-1], b_q[STAGES-1], cm_w};

endmodule

// File: doc/rca_pipe_nbit.md
RCA_PIPE_NBIT -- requirements
Module: rca_pipe_nbit

Interface
REQ-001 Parameter WIDTH, default 32, operand width in bits; SHALL be >= 2.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; SHALL be >= 1, and WIDTH % STAGES SHALL equal 0 (elaboration-time assertion).
REQ-003 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 in_valid  input  1  operand set present.
REQ-006 in_ready  output  1  block accepts an operand set this cycle.
REQ-007 a  input  WIDTH  operand A.
REQ-008 b  input  WIDTH  operand B.
REQ-009 cin  input  1  carry-in; used only in ADD mode.
REQ-010 op  input  op_e  OP_ADD or OP_SUB.
REQ-011 out_valid  output  1  result present.
REQ-012 out_ready  input  1  consumer accepts the result.
REQ-013 sum  output  WIDTH  result bits [WIDTH-1:0].
REQ-014 cout  output  1  carry-out of the MSB; in SUB mode, 1 means no borrow.
REQ-015 ovf  output  1  signed (two's-complement) overflow.

Function
REQ-016 An input transfer SHALL occur on a clock edge where in_valid && in_ready; an output transfer SHALL occur on a clock edge where out_valid && out_ready.
REQ-017 ADD: {cout,sum} SHALL equal a + b + cin, modulo 2^(WIDTH+1).
REQ-018 SUB: {cout,sum} SHALL equal a + ~b + 1, with cin ignored.
REQ-019 ovf SHALL equal (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]), where b_eff is b in ADD mode and ~b in SUB mode.
REQ-020 The datapath SHALL be split into STAGES slices of W = WIDTH/STAGES bits, with slice k computed in stage k.
REQ-021 The carry between slices SHALL be registered. Not-yet-consumed operand slices and completed sum slices SHALL be carried forward in skew registers.
REQ-022 The pipeline SHALL advance under one global enable, adv = !out_valid || out_ready; in_ready SHALL equal adv.
REQ-023 Latency SHALL be exactly STAGES cycles from input transfer to out_valid when not stalled.
REQ-024 Throughput SHALL be one result per cycle when out_ready is held high.
REQ-025 Each stage SHALL carry a valid bit. Bubbles SHALL propagate and SHALL NOT collapse; out_valid is the last stage's valid bit.
REQ-026 While adv = 0, every stage register, sum, cout, ovf and out_valid SHALL hold unchanged.
REQ-027 When in_valid = 0 on an advancing edge, a bubble SHALL enter stage 0; the data registers of that stage are don't-care.
REQ-028 Simultaneous input and output transfers SHALL be allowed on the same edge without loss or duplication.
REQ-029 When STAGES = 1, the block SHALL degenerate to a single registered adder with 1-cycle latency and the same handshake.
REQ-030 sum, cout and ovf SHALL be driven directly from last-stage registers, with no combinational path from a or b to the outputs.

Reset
REQ-031 While rst_n = 0, all stage valid bits and out_valid SHALL be 0 and in_ready SHALL be 1. Data registers, sum, cout and ovf SHALL be reset to 0.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight results; after release, no stale result SHALL appear on out_valid.
REQ-033 The first input transfer SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-034 Package rca_pkg SHALL hold typedef enum logic op_e {OP_ADD, OP_SUB}; rca_pipe_nbit SHALL import it.
REQ-035 One sub-module, rca_slice, SHALL be used: a parametrised W-bit combinational ripple-carry slice built from the existing full_adder cell.
REQ-036 rca_slice ports SHALL be a, b, cin, sum, cout and, for the MSB slice's overflow term, c_msb_in (carry into the slice's top bit).
REQ-037 rca_pipe_nbit SHALL instantiate rca_slice STAGES times with a generate loop; stage registers SHALL live in rca_pipe_nbit.

Verification (WIDTH=8, STAGES=2 unless stated)
REQ-038 ADD a=0xFF, b=0x01, cin=0 -> after 2 cycles sum=0x00, cout=1, ovf=0.
REQ-039 SUB a=0x05, b=0x07, cin=1 -> sum=0xFE, cout=0, ovf=0; cin has no effect.
REQ-040 ADD a=0x7F, b=0x01, cin=0 -> sum=0x80, ovf=1; SUB a=0x80, b=0x01 -> sum=0x7F, ovf=1, cout=1.
REQ-041 Stream 8 back-to-back transfers with out_ready=1 -> 8 correct results on 8 consecutive cycles starting at cycle 2. Repeat with out_ready low for 3 cycles mid-stream -> outputs held stable, in_ready=0 while stalled, no loss and no duplication.
REQ-042 Assert rst_n=0 with 2 transfers in flight -> out_valid=0 immediately, sum=0, and no result emerges after release.
REQ-043 Randomised 10k transfers on WIDTH=32/STAGES=4 and WIDTH=16/STAGES=1 with random in_valid and out_ready -> scoreboard matches REQ-017 to REQ-019 in order.
